// File: rtl/codec_seq_pkg.sv
// rtl/codec_seq_pkg.sv - shared state encoding and codec init table for the I2C sequencer
package codec_seq_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP      = 3'd0,
      ST_INIT_ISSUE = 3'd1,
      ST_INIT_WAIT  = 3'd2,
      ST_SW_IDLE    = 3'd3,
      ST_SW_ISSUE   = 3'd4,
      ST_SW_WAIT    = 3'd5
   } seq_state_e;

   localparam int INIT_LEN = 11;
   localparam int IDX_W    = $clog2(INIT_LEN);

   localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
      16'h1E00, 16'h0C72, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
      16'h0810, 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201
   };

   // Indices past the table cannot be reached; they read as zero.
   function automatic logic [15:0] init_word(input logic [IDX_W-1:0] idx);
      return (idx < IDX_W'(INIT_LEN)) ? INIT_TABLE[idx] : 16'h0000;
   endfunction

endpackage

// File: rtl/codec_seq_pwrup_timer.sv
// rtl/codec_seq_pwrup_timer.sv - loadable down-counter with done flag for the power-up delay
module codec_seq_pwrup_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/codec_i2c_sequencer.sv
// rtl/codec_i2c_sequencer.sv - codec init + software register writes over an I2C master
// Optional NACK retry enabled by defining CODEC_SEQ_RETRY_EN.
module codec_i2c_sequencer
   import codec_seq_pkg::*;
#(
   parameter int         PWRUP_CYCLES = 1000,
   parameter logic [6:0] DEV_ADDR     = 7'h1A,
   parameter int         MAX_RETRY    = 3
) (
   input  logic        s00_axi_aclk,
   input  logic        s00_axi_aresetn,
   input  logic        sw_req_valid,
   output logic        sw_req_ready,
   input  logic [6:0]  sw_req_addr,
   input  logic [8:0]  sw_req_data,
   output logic        sw_resp_valid,
   output logic        sw_resp_nack,
   output logic        i2c_cmd_valid,
   input  logic        i2c_cmd_ready,
   output logic [6:0]  i2c_cmd_dev,
   output logic [15:0] i2c_cmd_data,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        init_done,
   output logic        init_error
);

   // Timer is loaded with PWRUP_CYCLES-1 so the exit edge itself is the last counted cycle.
   localparam int         PW_W    = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
   localparam logic [PW_W-1:0] PW_LOAD = (PWRUP_CYCLES > 0) ? PW_W'(PWRUP_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

   seq_state_e       r_state;
   seq_state_e       w_next;
   logic [IDX_W-1:0] r_idx;
   logic [6:0]       r_sw_addr;
   logic [8:0]       r_sw_data;
   logic             r_resp_valid;
   logic             r_resp_nack;
   logic             r_init_done;
   logic             r_init_error;
   logic             w_pwrup_done;
   logic             w_wait_done;
   logic             w_retry_ok;
   logic             w_retry;

   codec_seq_pwrup_timer #(
      .WIDTH (PW_W)
   ) u_pwrup_timer (
      .clk        (s00_axi_aclk),
      .i_load     (!s00_axi_aresetn),
      .i_load_val (PW_LOAD),
      .i_en       (r_state == ST_PWRUP),
      .o_done     (w_pwrup_done)
   );

   assign w_wait_done = i2c_done && ((r_state == ST_INIT_WAIT) || (r_state == ST_SW_WAIT));
   assign w_retry     = i2c_nack && w_retry_ok;

`ifdef CODEC_SEQ_RETRY_EN
   localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RT_W-1:0] r_retry;

   // Every completed transaction either bumps the count (retry) or starts a fresh word.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_retry <= '0;
      end else if (w_wait_done) begin
         r_retry <= w_retry ? r_retry + 1'b1 : '0;
      end
   end

   assign w_retry_ok = (r_retry < RT_W'(MAX_RETRY));
`else
   assign w_retry_ok = 1'b0;
`endif

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_state <= ST_PWRUP;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      i2c_cmd_valid = 1'b0;
      i2c_cmd_data  = 16'h0000;
      sw_req_ready  = 1'b0;
      case (r_state)
         ST_PWRUP: begin
            if (w_pwrup_done) w_next = ST_INIT_ISSUE;
         end
         ST_INIT_ISSUE: begin
            i2c_cmd_valid = 1'b1;
            i2c_cmd_data  = init_word(r_idx);
            if (i2c_cmd_ready) w_next = ST_INIT_WAIT;
         end
         ST_INIT_WAIT: begin
            if (i2c_done) begin
               if (w_retry)                       w_next = ST_INIT_ISSUE;
               else if (i2c_nack || (r_idx == LAST_IDX)) w_next = ST_SW_IDLE;
               else                               w_next = ST_INIT_ISSUE;
            end
         end
         ST_SW_IDLE: begin
            sw_req_ready = 1'b1;
            if (sw_req_valid) w_next = ST_SW_ISSUE;
         end
         ST_SW_ISSUE: begin
            i2c_cmd_valid = 1'b1;
            i2c_cmd_data  = {r_sw_addr, r_sw_data};
            if (i2c_cmd_ready) w_next = ST_SW_WAIT;
         end
         ST_SW_WAIT: begin
            if (i2c_done) w_next = w_retry ? ST_SW_ISSUE : ST_SW_IDLE;
         end
         default: w_next = ST_PWRUP;
      endcase
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_idx        <= '0;
         r_sw_addr    <= '0;
         r_sw_data    <= '0;
         r_resp_valid <= 1'b0;
         r_resp_nack  <= 1'b0;
         r_init_done  <= 1'b0;
         r_init_error <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_nack  <= 1'b0;
         if ((r_state == ST_INIT_WAIT) && i2c_done && !w_retry) begin
            if (i2c_nack) begin
               r_init_error <= 1'b1;
               r_init_done  <= 1'b1;
            end else if (r_idx == LAST_IDX) begin
               r_init_done  <= 1'b1;
            end else begin
               r_idx        <= r_idx + 1'b1;
            end
         end
         if ((r_state == ST_SW_IDLE) && sw_req_valid) begin
            r_sw_addr <= sw_req_addr;
            r_sw_data <= sw_req_data;
         end
         if ((r_state == ST_SW_WAIT) && i2c_done && !w_retry) begin
            r_resp_valid <= 1'b1;
            r_resp_nack  <= i2c_nack;
         end
      end
   end

   assign i2c_cmd_dev   = DEV_ADDR;
   assign sw_resp_valid = r_resp_valid;
   assign sw_resp_nack  = r_resp_nack;
   assign init_done     = r_init_done;
   assign init_error    = r_init_error;

endmodule

// File: doc/codec_i2c_sequencer.md
CODEC_I2C_SEQUENCER -- requirements
Module: codec_i2c_sequencer

Interface
REQ-001 The module SHALL have these parameters:
- PWRUP_CYCLES, 1000: cycles to wait after reset release before the first command.
- DEV_ADDR, 7'h1A: 7-bit I2C codec device address.
- MAX_RETRY, 3: re-issues allowed after a NACK (used only with the retry macro).

REQ-002 The module SHALL have these ports (one clock; reset is synchronous and active-low):
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- sw_req_valid  in  1  software write request.
- sw_req_ready  out  1  request accepted when valid&ready.
- sw_req_addr  in  7  codec register address.
- sw_req_data  in  9  codec register data.
- sw_resp_valid  out  1  one-cycle completion pulse.
- sw_resp_nack  out  1  qualifies sw_resp_valid; 1 = failed.
- i2c_cmd_valid  out  1  command to the I2C master.
- i2c_cmd_ready  in  1  master accepts the command.
- i2c_cmd_dev  out  7  always DEV_ADDR.
- i2c_cmd_data  out  16  {reg_addr[6:0], reg_data[8:0]}.
- i2c_done  in  1  one-cycle pulse, transaction finished.
- i2c_nack  in  1  qualifies i2c_done.
- init_done  out  1  init sequence finished (sticky).
- init_error  out  1  init aborted on NACK (sticky).

Function
REQ-003 The FSM SHALL have states PWRUP, INIT_ISSUE, INIT_WAIT, SW_IDLE, SW_ISSUE, SW_WAIT.
REQ-004 PWRUP SHALL count PWRUP_CYCLES cycles, so i2c_cmd_valid first rises exactly PWRUP_CYCLES cycles after reset deasserts.
REQ-005 INIT_ISSUE SHALL drive INIT_TABLE[idx] with i2c_cmd_valid=1 and hold data stable until i2c_cmd_ready=1, then go to INIT_WAIT.
REQ-006 INIT_WAIT SHALL wait for i2c_done:
- No NACK: increment idx; return to INIT_ISSUE, or after the last entry go to SW_IDLE with init_done=1.
- NACK (retries exhausted): set init_error=1 and init_done=1, skip the remaining entries, go to SW_IDLE.
REQ-007 sw_req_ready SHALL be 1 only in SW_IDLE; it is 0 throughout initialization, so init always has priority.
REQ-008 On sw_req_valid&sw_req_ready the module SHALL:
- capture the address and data;
- go to SW_ISSUE, present {addr,data} with the same handshake as init, then go to SW_WAIT.
REQ-009 In SW_WAIT, on i2c_done the module SHALL:
- pulse sw_resp_valid for one cycle in the next cycle, with sw_resp_nack = final NACK status;
- return to SW_IDLE.
REQ-010 i2c_done pulses arriving outside INIT_WAIT/SW_WAIT SHALL be ignored.
REQ-011 At most one I2C transaction SHALL be outstanding, and i2c_cmd_valid SHALL never be 1 in a WAIT state.
REQ-012 idx SHALL be exactly $clog2(INIT_LEN) bits and SHALL NOT wrap: completion is detected at idx==INIT_LEN-1.

Reset
REQ-013 When s00_axi_aresetn=0 at a clock edge, the module SHALL:
- enter PWRUP with counter, idx and retry count cleared;
- clear every output (i2c_cmd_data=0, i2c_cmd_dev=DEV_ADDR).
REQ-014 Reset mid-transaction SHALL abandon the transaction without a response pulse and SHALL restart the full init sequence.

Configuration
REQ-015 With CODEC_SEQ_RETRY_EN defined:
- a NACK SHALL re-enter the corresponding ISSUE state with the same word, up to MAX_RETRY times per word;
- the retry count SHALL reset on each new word;
- only a NACK after MAX_RETRY retries is final.
REQ-016 Without CODEC_SEQ_RETRY_EN, the first NACK SHALL be final and no retry counter logic SHALL be synthesized.

Structure
REQ-017 Package codec_seq_pkg SHALL hold:
- the state enum;
- INIT_LEN=11;
- INIT_TABLE of 16-bit words: 0x1E00, 0x0C72, 0x0017, 0x0217, 0x0479, 0x0679, 0x0810, 0x0A00, 0x0E0A, 0x1000, 0x1201.
REQ-018 Sub-module codec_seq_pwrup_timer (loadable down-counter with a done flag) SHALL implement the PWRUP delay; all other logic stays in one module.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, PWRUP_CYCLES=10, master always ready and ACK -> first i2c_cmd_valid at cycle 10 with data 0x1E00; 11 words issued in table order; init_done=1 after the 11th i2c_done.
- sw_req_valid held high during init -> sw_req_ready stays 0; the request is accepted the cycle after SW_IDLE is entered; addr 0x06 / data 0x062 issued as 0x0C62.
- NACK on the 3rd init word without the macro -> init_error=1, init_done=1, no further init commands.
- With CODEC_SEQ_RETRY_EN, MAX_RETRY=3: software write NACKed twice then ACKed -> 3 issues of the same word, then sw_resp_valid=1 with sw_resp_nack=0; NACKed 4 times -> sw_resp_nack=1.
- i2c_cmd_ready held 0 for 5 cycles -> i2c_cmd_valid and i2c_cmd_data stable throughout; a spurious i2c_done in SW_IDLE produces no response.
- Reset asserted in INIT_WAIT -> all outputs clear next cycle; no sw_resp pulse; sequence restarts with 0x1E00.
